// File: rtl/ifetch_unit.sv
// Instruction fetch unit: turns accepted fetch addresses into ordered memory reads
// and returns {pc, instruction} pairs, with credit-based flow control and flush.
module ifetch_unit #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pc_valid_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            pc_ready_o,
    input  logic            flush_i,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [31:0]     mem_rdata_i,
    output logic            instr_v_o,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    input  logic            instr_ok_i,
    output logic            proto_err_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int UW = CW + 2;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {S_IDLE, S_REQ} state_e;
    typedef logic [CW-1:0] cnt_t;
    typedef logic [PW-1:0] ptr_t;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    cnt_t            out_q, out_d;
    cnt_t            kill_q, kill_d;
    cnt_t            rf_cnt_q, rf_cnt_d;
    ptr_t            pq_wptr_q, pq_wptr_d, pq_rptr_q, pq_rptr_d;
    ptr_t            rf_wptr_q, rf_wptr_d, rf_rptr_q, rf_rptr_d;
    logic            proto_err_q, proto_err_d;

    logic [XLEN-1:0] pq_pc_q   [DEPTH];
    logic [XLEN-1:0] rf_pc_q   [DEPTH];
    logic [31:0]     rf_data_q [DEPTH];

    logic            grant, rv_ok, rv_kill, pending, accept;
    logic            pq_push, pq_pop, rf_push, rf_pop;
    cnt_t            rf_occ;
    logic [UW-1:0]   used;

    // Credit check uses registered occupancy only, so a pop frees its slot one cycle later.
    always_comb begin
        grant      = (state_q == S_REQ) && mem_gnt_i;
        rv_ok      = mem_rvalid_i && (out_q != '0);
        rv_kill    = rv_ok && (kill_q != '0);
        rf_occ     = flush_i ? '0 : rf_cnt_q;
        // A flushed ungranted request is withdrawn; a granted one still owns a slot.
        pending    = flush_i ? grant : (state_q == S_REQ);
        used       = UW'(rf_occ) + UW'(out_q) + UW'(pending);
        pc_ready_o = ((state_q == S_IDLE) || grant || flush_i) && (used < UW'(DEPTH));
        accept     = pc_valid_i && pc_ready_o;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (accept) begin
            state_d = S_REQ;
            pc_d    = pc_i;
        end else if (grant || flush_i) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        out_d   = out_q + cnt_t'(grant) - cnt_t'(rv_ok);
        kill_d  = kill_q;
        if (flush_i) begin
            kill_d = out_d;
        end else if (rv_kill) begin
            kill_d = kill_q - cnt_t'(1);
        end

        // PC queue entries track every granted read, killed or not, and drain with responses.
        pq_push   = grant;
        pq_pop    = rv_ok;
        pq_wptr_d = pq_push ? ptr_inc(pq_wptr_q) : pq_wptr_q;
        pq_rptr_d = pq_pop  ? ptr_inc(pq_rptr_q) : pq_rptr_q;

        rf_push = rv_ok && !rv_kill && !flush_i;
        rf_pop  = instr_v_o && instr_ok_i && !flush_i;
        if (flush_i) begin
            rf_cnt_d  = '0;
            rf_wptr_d = '0;
            rf_rptr_d = '0;
        end else begin
            rf_cnt_d  = rf_cnt_q + cnt_t'(rf_push) - cnt_t'(rf_pop);
            rf_wptr_d = rf_push ? ptr_inc(rf_wptr_q) : rf_wptr_q;
            rf_rptr_d = rf_pop  ? ptr_inc(rf_rptr_q) : rf_rptr_q;
        end

        proto_err_d = proto_err_q || (mem_rvalid_i && (out_q == '0));
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            out_q       <= '0;
            kill_q      <= '0;
            pq_wptr_q   <= '0;
            pq_rptr_q   <= '0;
            rf_cnt_q    <= '0;
            rf_wptr_q   <= '0;
            rf_rptr_q   <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_q       <= out_d;
            kill_q      <= kill_d;
            pq_wptr_q   <= pq_wptr_d;
            pq_rptr_q   <= pq_rptr_d;
            rf_cnt_q    <= rf_cnt_d;
            rf_wptr_q   <= rf_wptr_d;
            rf_rptr_q   <= rf_rptr_d;
            proto_err_q <= proto_err_d;
        end
    end

    // NOTE: storage arrays have no reset; counts and pointers decide which entries are live.
    always_ff @(posedge clk) begin
        if (pq_push) begin
            pq_pc_q[pq_wptr_q] <= pc_q;
        end
        if (rf_push) begin
            rf_pc_q[rf_wptr_q]   <= pq_pc_q[pq_rptr_q];
            rf_data_q[rf_wptr_q] <= mem_rdata_i;
        end
    end

    assign mem_req_o   = (state_q == S_REQ);
    assign mem_addr_o  = {pc_q[XLEN-1:2], 2'b00};
    assign instr_v_o   = (rf_cnt_q != '0);
    assign instr_o     = instr_v_o ? rf_data_q[rf_rptr_q] : '0;
    assign instr_pc_o  = instr_v_o ? rf_pc_q[rf_rptr_q] : '0;
    assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: in-order memory model plus an instruction
// scoreboard filled on pc acceptance and drained when instructions are consumed.
module tb_ifetch_unit;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            pc_valid_i;
    logic [XLEN-1:0] pc_i;
    logic            pc_ready_o;
    logic            flush_i;
    logic            mem_req_o;
    logic [XLEN-1:0] mem_addr_o;
    logic            mem_gnt_i;
    logic            mem_rvalid_i;
    logic [31:0]     mem_rdata_i;
    logic            instr_v_o;
    logic [31:0]     instr_o;
    logic [XLEN-1:0] instr_pc_o;
    logic            instr_ok_i;
    logic            proto_err_o;

    ifetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_valid_i   (pc_valid_i),
        .pc_i         (pc_i),
        .pc_ready_o   (pc_ready_o),
        .flush_i      (flush_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .instr_v_o    (instr_v_o),
        .instr_o      (instr_o),
        .instr_pc_o   (instr_pc_o),
        .instr_ok_i   (instr_ok_i),
        .proto_err_o  (proto_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } rsp_t;

    exp_t exp_q[$];
    rsp_t rsp_q[$];

    int n_checks    = 0;
    int n_fail      = 0;
    int cyc         = 0;
    int lat         = 1;
    int stall_left  = 0;
    bit spur        = 1'b0;
    int acc_cnt     = 0;
    int pop_cnt     = 0;
    int max_used    = 0;
    int last_rv_cyc = -100;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a == 32'h100) ? 32'h0000_0013 : {a[15:0], ~a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory model and instruction monitor: drive at negedge, observe 1 ns later.
    initial begin
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        forever begin
            @(negedge clk);
            mem_gnt_i = 1'b1;
            if (mem_req_o && stall_left > 0) begin
                mem_gnt_i = 1'b0;
                stall_left--;
            end
            if (mem_req_o && mem_gnt_i) rsp_q.push_back('{cyc + lat, mem_addr_o});
            mem_rvalid_i = 1'b0;
            if (spur) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = 32'hdead_beef;
                spur         = 1'b0;
            end else if (rsp_q.size() != 0 && rsp_q[0].due <= cyc) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = mem_data(rsp_q[0].addr);
                rsp_q.pop_front();
                last_rv_cyc  = cyc;
            end
            #1;
            if (rst_n && instr_v_o && instr_ok_i) begin
                pop_cnt++;
                if (exp_q.size() == 0) begin
                    check("sb_nonempty", 1'b0, 1'b1 && (exp_q.size() == 0));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("instr_pc", instr_pc_o, e.pc);
                    check("instr", instr_o, e.data);
                end
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (acc_cnt - pop_cnt > max_used) max_used = acc_cnt - pop_cnt;
    end

    // Offer pc at the current negedge; optional flush on the first offered cycle only.
    task automatic send_pc(input logic [31:0] pc, input bit with_flush);
        bit acc;
        acc        = 1'b0;
        pc_valid_i = 1'b1;
        pc_i       = pc;
        flush_i    = with_flush;
        if (with_flush) exp_q.delete();
        for (int i = 0; i < 100 && !acc; i++) begin
            #1;
            if (pc_ready_o) begin
                acc = 1'b1;
                acc_cnt++;
                exp_q.push_back('{pc, mem_data({pc[31:2], 2'b00})});
            end
            @(negedge clk);
            flush_i = 1'b0;
        end
        pc_valid_i = 1'b0;
        check("pc_accept", acc, 1'b1);
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound && (exp_q.size() != 0 || rsp_q.size() != 0); i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("drain", exp_q.size(), 0);
    endtask

    task automatic wait_instr(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (instr_v_o) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bit seen;
        rst_n      = 1'b0;
        pc_valid_i = 1'b0;
        pc_i       = '0;
        flush_i    = 1'b0;
        instr_ok_i = 1'b1;

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        check("rst_mem_req", mem_req_o, 1'b0);
        check("rst_mem_addr", mem_addr_o, 32'h0);
        check("rst_instr_v", instr_v_o, 1'b0);
        check("rst_instr", instr_o, 32'h0);
        check("rst_instr_pc", instr_pc_o, 32'h0);
        check("rst_proto_err", proto_err_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", pc_ready_o, 1'b1);
        @(negedge clk);

        // Single fetch, response two cycles after grant
        lat = 2;
        send_pc(32'h100, 1'b0);
        #1;
        check("single_req", mem_req_o, 1'b1);
        check("single_addr", mem_addr_o, 32'h100);
        wait_instr(seen);
        check("single_seen", seen, 1'b1);
        check("single_latency", cyc - last_rv_cyc, 1);
        @(negedge clk);
        drain(50);

        // Grant stall: request held for four cycles
        lat        = 1;
        stall_left = 3;
        send_pc(32'h200, 1'b0);
        for (int k = 0; k < 4; k++) begin
            #1;
            check("stall_req", mem_req_o, 1'b1);
            check("stall_addr", mem_addr_o, 32'h200);
            check("stall_ready", pc_ready_o, k == 3);
            @(negedge clk);
        end
        #1;
        check("stall_req_drop", mem_req_o, 1'b0);
        @(negedge clk);
        drain(50);

        // Streaming with slot-usage tracking
        max_used = 0;
        send_pc(32'h0, 1'b0);
        send_pc(32'h4, 1'b0);
        #1;
        check("b2b_req", mem_req_o, 1'b1);
        check("b2b_addr", mem_addr_o, 32'h4);
        @(negedge clk);
        send_pc(32'h8, 1'b0);
        drain(100);
        check("stream_max_slots", max_used <= DEPTH, 1'b1);

        // Backpressure: two buffered responses block new fetches
        instr_ok_i = 1'b0;
        send_pc(32'h40, 1'b0);
        send_pc(32'h46, 1'b0);
        repeat (5) @(negedge clk);
        #1;
        check("bp_ready", pc_ready_o, 1'b0);
        check("bp_req", mem_req_o, 1'b0);
        check("bp_instr_v", instr_v_o, 1'b1);
        check("bp_head_pc", instr_pc_o, 32'h40);
        @(negedge clk);
        instr_ok_i = 1'b1;
        @(negedge clk);
        instr_ok_i = 1'b0;
        #1;
        check("bp_ready_after_pop", pc_ready_o, 1'b1);
        @(negedge clk);
        instr_ok_i = 1'b1;
        drain(50);

        // Flush in the grant cycle of the second request, redirect to 0x400
        lat = 4;
        send_pc(32'h80, 1'b0);
        send_pc(32'h84, 1'b0);
        send_pc(32'h400, 1'b1);
        drain(100);
        lat = 1;

        // Spurious response sets sticky error, reset clears it
        #1;
        check("no_proto_err", proto_err_o, 1'b0);
        @(negedge clk);
        spur = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("spur_err", proto_err_o, 1'b1);
        check("spur_instr_v", instr_v_o, 1'b0);
        @(negedge clk);
        #1;
        check("spur_err_sticky", proto_err_o, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("err_cleared", proto_err_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
